// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: serial adder reusing one 4-bit ripple stage once per
// nibble, LSB nibble first, under an IDLE/RUN/DONE controller.
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input selecting a-b.

// Single-bit full adder cell used to build the ripple stage.
module fullAdderUnit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
`ifdef SERIAL_ADD_SUB_EN
   input  logic                   sub,
`endif
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [W-1:0]  opa;
   logic [W-1:0]  opb;
   logic [W-1:0]  sum_r;
   logic          cout_r;
   logic          carry;
   logic [IW-1:0] idx;
   logic          last;

   logic [3:0]    na;
   logic [3:0]    nb;
   logic [3:0]    ns;
   logic [4:0]    c;

   logic [W-1:0]  b_cap;
   logic          c_init;

   // Subtraction is a+~b+1: invert b on capture and seed the carry with 1.
`ifdef SERIAL_ADD_SUB_EN
   assign b_cap  = sub ? ~b : b;
   assign c_init = sub;
`else
   assign b_cap  = b;
   assign c_init = 1'b0;
`endif

   assign na   = opa[{idx, 2'b00} +: 4];
   assign nb   = opb[{idx, 2'b00} +: 4];
   assign c[0] = carry;
   assign last = (idx == IW'(NIBBLES - 1));

   for (genvar i = 0; i < 4; i++) begin : g_stage
      fullAdderUnit u_fa (
         .a    (na[i]),
         .b    (nb[i]),
         .cin  (c[i]),
         .s    (ns[i]),
         .cout (c[i+1])
      );
   end

   // Controller, operand capture and per-nibble result/carry update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         opa    <= '0;
         opb    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  opa   <= a;
                  opb   <= b_cap;
                  carry <= c_init;
                  idx   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               sum_r[{idx, 2'b00} +: 4] <= ns;
               carry <= c[4];
               idx   <= idx + 1'b1;
               if (last) begin
                  cout_r <= c[4];
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ready = (state == IDLE) || (state == DONE);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);
   assign sum   = sum_r;
   assign cout  = cout_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl (NIBBLES=4): the driver pushes
// hand-computed results with the cycle they must appear; the monitor pops and
// compares each done pulse.
module tb_nibble_serial_add_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        ready, busy, done, cout;
   logic [15:0] sum;

   typedef struct {
      logic [15:0] s;
      logic        c;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic prev_done = 1'b0;

   nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Monitor: every done pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && done) begin
         checks++;
         if (prev_done) begin
            failures++;
            $display("FAIL done_width: done high two cycles in a row at cyc %0d", cyc);
         end
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: got sum=%h cout=%b at cyc %0d, required no done", sum, cout, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (sum !== e.s || cout !== e.c) begin
               failures++;
               $display("FAIL result: got sum=%h cout=%b, required sum=%h cout=%b", sum, cout, e.s, e.c);
            end
            checks++;
            if (cyc != e.cyc) begin
               failures++;
               $display("FAIL latency: done at cyc %0d, required cyc %0d", cyc, e.cyc);
            end
         end
      end
      prev_done = done;
   end

   // Wait at a falling edge until the DUT is ready, with a cycle budget.
   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!ready) begin
         failures++;
         $display("FAIL ready_timeout: ready=%b, required 1", ready);
      end
   endtask

   // Issue one operation and record its expected result and done cycle.
   task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic [15:0] es, input logic ec);
      exp_t e;
      wait_ready();
      a = x; b = y; sub = s; start = 1'b1;
      e.s = es; e.c = ec; e.cyc = cyc + 5;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Let the scoreboard drain, bounded.
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic check_idle(input string tag);
      checks++;
      if (sum !== 16'h0000 || cout !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s: got sum=%h cout=%b ready=%b busy=%b done=%b, required 0000 0 1 0 0",
                  tag, sum, cout, ready, busy, done);
      end
   endtask

   initial begin
      exp_t e;
      int   c0;
      repeat (3) @(negedge clk);
      check_idle("reset_state");
      rst = 1'b0;

      issue(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
      issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
      issue(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
      issue(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0);

      // Start during RUN with new operands must be ignored.
      issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
      a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_in_run: got busy=%b, required 1", busy);
      end
      start = 1'b0;
      drain();

      // Abort two cycles into RUN: no done, outputs cleared.
      wait_ready();
      a = 16'h5555; b = 16'h1111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("abort_reset");
      repeat (8) @(negedge clk);
      issue(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
      drain();

      // Back-to-back: start held through DONE.
      wait_ready();
      c0 = cyc;
      a = 16'h0001; b = 16'h0001; start = 1'b1;
      e.s = 16'h0002; e.c = 1'b0; e.cyc = c0 + 5;
      exp_q.push_back(e);
      e.s = 16'h0004; e.c = 1'b0; e.cyc = c0 + 10;
      exp_q.push_back(e);
      @(negedge clk);
      a = 16'h0002; b = 16'h0002;
      repeat (5) @(negedge clk);
      start = 1'b0;
      drain();

`ifdef SERIAL_ADD_SUB_EN
      issue(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
      issue(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
      issue(16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
      drain();
`endif

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, sets the number of 4-bit nibbles per operand; legal range is 2..16.
REQ-002 Port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-004 Port start, input, 1 bit, request for a new operation, sampled only when ready=1.
REQ-005 Ports a and b, input, 4*NIBBLES bits each, operands captured on the accepted start.
REQ-006 Port ready, output, 1 bit, high when a start will be accepted (IDLE or DONE state).
REQ-007 Port busy, output, 1 bit, high while in RUN.
REQ-008 Port done, output, 1 bit, single-cycle pulse marking valid sum/cout.
REQ-009 Port sum, output, 4*NIBBLES bits, result, held until the next accepted start completes.
REQ-010 Port cout, output, 1 bit, carry out of the most significant nibble, held like sum.

Function
REQ-011 The block SHALL contain exactly one 4-bit ripple stage built from fullAdderUnit cells with a registered carry-in, and it SHALL reuse that stage once per nibble, LSB nibble first.
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-013 In IDLE or DONE, start=1 SHALL capture a and b into operand registers, clear the carry register and the nibble index, and move the FSM to RUN.
REQ-014 In RUN, each cycle SHALL add nibble[idx] of the captured a and b plus the carry register, write the 4-bit result into sum nibble[idx], update the carry register and increment idx.
REQ-015 In RUN, when idx=NIBBLES-1 the FSM SHALL move to DONE on that same edge and load cout from the final carry.
REQ-016 DONE SHALL last exactly one cycle with done=1; without a start it SHALL return to IDLE.
REQ-017 Latency SHALL be: start accepted at edge k, done high during the cycle after edge k+NIBBLES, i.e. NIBBLES+1 cycles from start to done.
REQ-018 A start seen during RUN SHALL be ignored and SHALL NOT alter the operands, idx or the carry.
REQ-019 A start seen in DONE SHALL be accepted (back-to-back operation), done SHALL still pulse in that DONE cycle, and the next done SHALL follow NIBBLES+1 cycles later.
REQ-020 The operands SHALL be fully registered; a and b SHALL NOT need to be held stable after the accepting edge.
REQ-021 The sum SHALL be modulo 2^(4*NIBBLES), with the overflow bit appearing only on cout.
REQ-022 sum and cout SHALL be updated only during RUN and at the RUN to DONE transition; their value is guaranteed valid only when done=1 or afterwards in IDLE.

Reset
REQ-023 With rst=1 at an edge, the state SHALL go to IDLE, idx and the carry to 0, and sum, cout and done to 0, giving ready=1 and busy=0.
REQ-024 rst SHALL take priority over start and abort any operation in progress, with no done pulse for the aborted operation.

Configuration
REQ-025 Macro SERIAL_ADD_SUB_EN, when defined, SHALL add port sub (input, 1 bit), captured with start.
REQ-026 With SERIAL_ADD_SUB_EN defined and sub=1, the block SHALL compute a-b: b is inverted on capture, the carry register is initialised to 1, and cout=1 means no borrow.
REQ-027 With SERIAL_ADD_SUB_EN defined and sub=0, and also when the macro is undefined, behaviour SHALL be identical to addition.
REQ-028 Without SERIAL_ADD_SUB_EN the block SHALL have no sub port and the carry SHALL always initialise to 0.

Verification (NIBBLES=4)
REQ-029 Start with a=0x00FF, b=0x0001 -> after 5 cycles done=1, sum=0x0100, cout=0.
REQ-030 Start with a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, done pulse exactly 1 cycle wide.
REQ-031 Start with a=0x1234, b=0x1111, then start with a=0xFFFF during RUN -> sum=0x2345, and the second start is ignored.
REQ-032 rst asserted 2 cycles into RUN -> next cycle sum=0, cout=0, ready=1, no done pulse; a new start with a=0x0003, b=0x0004 -> sum=0x0007.
REQ-033 Back-to-back: start held high through DONE with a=0x0001, b=0x0001 then a=0x0002, b=0x0002 -> done pulses 5 cycles apart giving 0x0002 then 0x0004.
REQ-034 With SERIAL_ADD_SUB_EN defined, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; with a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
